// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator sequencer.
// State encoding, operand-select / display-mode / error codes and a busy decode helper.
package calc_pkg;

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      CHECK,
      LAUNCH,
      WAIT_RES,
      CONVERT,
      SHOW,
      ERROR
   } state_t;

   typedef enum logic [1:0] {
      SEL_A       = 2'd0,
      SEL_B       = 2'd1,
      SEL_COMPUTE = 2'd2
   } sel_t;

   typedef enum logic [1:0] {
      DM_INPUT  = 2'd0,
      DM_RESULT = 2'd1,
      DM_ERROR  = 2'd2
   } disp_mode_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BADOP   = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_t;

   // The sequencer counts as busy while an operation is being validated or computed.
   function automatic logic is_busy(input state_t s);
      return (s == CHECK) || (s == LAUNCH) || (s == WAIT_RES) || (s == CONVERT);
   endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: handshake between the sequencer (master) and the
// arithmetic unit / display conversion pair (slave).
interface calc_sequencer_if #(
   parameter int OP_W = 11
);
   logic            start_out;
   logic [OP_W-1:0] op_latched;
   logic            conversion_en;
   logic            result_ready_in;
   logic            conversion_ready;

   modport master (
      output start_out,
      output op_latched,
      output conversion_en,
      input  result_ready_in,
      input  conversion_ready
   );

   modport slave (
      input  start_out,
      input  op_latched,
      input  conversion_en,
      output result_ready_in,
      output conversion_ready
   );
endinterface

// File: rtl/calc_sequencer_seq_timer.sv
// seq_timer: clearable, enabled, saturating cycle counter.
// expired is high once the count has reached TIMEOUT_CYC-1.
module seq_timer #(
   parameter int CNT_W       = 20,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Count up while enabled, stick at all-ones rather than wrap; clear has priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand entry, op validation, compute launch with timeout,
// display conversion request and display mode control.
// Optional macro CALC_CHAIN_EN: from SHOW, btn_next reuses the result as operand A
// and jumps to B entry (or straight to CHECK for a unary op), flagged by chain_out.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int              OP_W        = 11,
   parameter logic [OP_W-1:0] UNARY_MASK  = '0,
   parameter int              TIMEOUT_CYC = 1_000_000,
   parameter int              CNT_W       = 20
) (
   input  logic                    CLK100MHz,
   input  logic                    reset,
   input  logic                    btn_next,
   input  logic                    btn_clear,
   input  logic [OP_W-1:0]         operation_in,
   calc_sequencer_if.master        arith_if,
   output logic [1:0]              operand_selection,
   output logic [1:0]              display_mode_out,
   output logic                    busy,
   output logic [1:0]              error_code,
   output logic                    chain_out
);

   state_t          state_q, state_d;
   sel_t            sel_q, sel_d;
   disp_mode_t      dm_q, dm_d;
   err_t            err_q, err_d;
   logic            start_q, start_d;
   logic            conv_q, conv_d;
   logic            busy_q, busy_d;
   logic [OP_W-1:0] op_q, op_d;

   logic op_unary, op_onehot;
   logic timer_en, timer_clear, timer_expired;

   assign op_unary  = |(operation_in & UNARY_MASK);
   assign op_onehot = (operation_in != '0) &&
                      ((operation_in & (operation_in - OP_W'(1))) == '0);

   // The timer only runs in the two waiting states and restarts on every state change.
   assign timer_en    = (state_q == WAIT_RES) || (state_q == CONVERT);
   assign timer_clear = !timer_en || (state_d != state_q);

   seq_timer #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (CLK100MHz),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   // State register.
   always_ff @(posedge CLK100MHz or negedge reset) begin
      if (!reset) begin
         state_q <= ENTER_A;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear beats everything, a result beats a simultaneous timeout.
   always_comb begin
      state_d = state_q;
      if (btn_clear) begin
         state_d = ENTER_A;
      end else begin
         case (state_q)
            ENTER_A:  if (btn_next) state_d = op_unary ? CHECK : ENTER_B;
            ENTER_B:  if (btn_next) state_d = CHECK;
            CHECK:    state_d = op_onehot ? LAUNCH : ERROR;
            LAUNCH:   state_d = WAIT_RES;
            WAIT_RES: begin
               if (arith_if.result_ready_in) state_d = CONVERT;
               else if (timer_expired)       state_d = ERROR;
            end
            CONVERT:  begin
               if (arith_if.conversion_ready) state_d = SHOW;
               else if (timer_expired)        state_d = ERROR;
            end
`ifdef CALC_CHAIN_EN
            SHOW:     if (btn_next) state_d = op_unary ? CHECK : ENTER_B;
`else
            SHOW:     if (btn_next) state_d = ENTER_A;
`endif
            ERROR:    if (btn_next) state_d = ENTER_A;
            default:  state_d = ENTER_A;
         endcase
      end
   end

   // Output decode from the upcoming state so every output is registered with the state.
   always_comb begin
      sel_d   = SEL_COMPUTE;
      dm_d    = DM_INPUT;
      err_d   = ERR_NONE;
      start_d = 1'b0;
      conv_d  = 1'b0;
      busy_d  = is_busy(state_d);
      op_d    = op_q;
      case (state_d)
         ENTER_A: sel_d = SEL_A;
         ENTER_B: sel_d = SEL_B;
         LAUNCH:  begin
            start_d = 1'b1;
            op_d    = operation_in;
         end
         CONVERT: conv_d = 1'b1;
         SHOW:    dm_d = DM_RESULT;
         ERROR:   begin
            dm_d = DM_ERROR;
            if (state_q == ERROR)      err_d = err_q;
            else if (state_q == CHECK) err_d = ERR_BADOP;
            else                       err_d = ERR_TIMEOUT;
         end
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge CLK100MHz or negedge reset) begin
      if (!reset) begin
         sel_q   <= SEL_A;
         dm_q    <= DM_INPUT;
         err_q   <= ERR_NONE;
         start_q <= 1'b0;
         conv_q  <= 1'b0;
         busy_q  <= 1'b0;
         op_q    <= '0;
      end else begin
         sel_q   <= sel_d;
         dm_q    <= dm_d;
         err_q   <= err_d;
         start_q <= start_d;
         conv_q  <= conv_d;
         busy_q  <= busy_d;
         op_q    <= op_d;
      end
   end

`ifdef CALC_CHAIN_EN
   logic chain_q;

   // Chain flag: set when a result is carried forward, dropped once CHECK is left or on clear.
   always_ff @(posedge CLK100MHz or negedge reset) begin
      if (!reset) begin
         chain_q <= 1'b0;
      end else if (btn_clear) begin
         chain_q <= 1'b0;
      end else if ((state_q == SHOW) && btn_next) begin
         chain_q <= 1'b1;
      end else if (state_q == CHECK) begin
         chain_q <= 1'b0;
      end
   end

   assign chain_out = chain_q;
`else
   assign chain_out = 1'b0;
`endif

   assign operand_selection      = sel_q;
   assign display_mode_out       = dm_q;
   assign error_code             = err_q;
   assign busy                   = busy_q;
   assign arith_if.start_out     = start_q;
   assign arith_if.conversion_en = conv_q;
   assign arith_if.op_latched    = op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer
// (UNARY_MASK = 11'h400, TIMEOUT_CYC = 16). Honours CALC_CHAIN_EN if defined.
module tb_calc_sequencer;

   logic        clk;
   logic        reset;
   logic        btn_next;
   logic        btn_clear;
   logic [10:0] operation_in;
   int          errors;
   int          checks;
   int          start_count;
   int          start_before;

   calc_sequencer_if #(.OP_W(11)) arith_bus ();

   logic [1:0] operand_selection;
   logic [1:0] display_mode_out;
   logic       busy;
   logic [1:0] error_code;
   logic       chain_out;

   calc_sequencer #(
      .OP_W        (11),
      .UNARY_MASK  (11'h400),
      .TIMEOUT_CYC (16),
      .CNT_W       (5)
   ) dut (
      .CLK100MHz         (clk),
      .reset             (reset),
      .btn_next          (btn_next),
      .btn_clear         (btn_clear),
      .operation_in      (operation_in),
      .arith_if          (arith_bus.master),
      .operand_selection (operand_selection),
      .display_mode_out  (display_mode_out),
      .busy              (busy),
      .error_code        (error_code),
      .chain_out         (chain_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every cycle in which the launch pulse is high.
   always @(posedge clk) begin
      if (arith_bus.start_out === 1'b1) start_count++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_next();
      btn_next = 1'b1;
      tick();
      btn_next = 1'b0;
   endtask

   task automatic press_clear();
      btn_clear = 1'b1;
      tick();
      btn_clear = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({operand_selection, display_mode_out, busy, error_code, chain_out,
           arith_bus.start_out, arith_bus.conversion_en} !== 11'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got sel=%0d dm=%0d busy=%0b err=%0d start=%0b conv=%0b",
                  operand_selection, display_mode_out, busy, error_code,
                  arith_bus.start_out, arith_bus.conversion_en);
      end
      checks++;
      if (arith_bus.op_latched !== 11'h000) begin
         errors++;
         $display("[TB] FAIL reset_op_latched: got %0h expected 0", arith_bus.op_latched);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_binary();
      start_before = start_count;
      operation_in = 11'h001;
      press_next();
      checks++;
      if (operand_selection !== 2'd1) begin
         errors++;
         $display("[TB] FAIL bin_sel_b: got %0d expected 1", operand_selection);
      end
      press_next();
      checks++;
      if (operand_selection !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bin_check: got sel=%0d busy=%0b expected sel=2 busy=1", operand_selection, busy);
      end
      tick();
      checks++;
      if (arith_bus.start_out !== 1'b1 || arith_bus.op_latched !== 11'h001) begin
         errors++;
         $display("[TB] FAIL bin_launch: got start=%0b op=%0h expected start=1 op=001",
                  arith_bus.start_out, arith_bus.op_latched);
      end
      tick();
      operation_in = 11'h004;
      checks++;
      if (arith_bus.start_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bin_start_width: got %0b expected 0", arith_bus.start_out);
      end
      repeat (4) tick();
      arith_bus.result_ready_in = 1'b1;
      tick();
      arith_bus.result_ready_in = 1'b0;
      checks++;
      if (arith_bus.conversion_en !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bin_convert: got conv=%0b busy=%0b expected 1 1", arith_bus.conversion_en, busy);
      end
      repeat (2) tick();
      arith_bus.conversion_ready = 1'b1;
      tick();
      arith_bus.conversion_ready = 1'b0;
      checks++;
      if (arith_bus.conversion_en !== 1'b0 || display_mode_out !== 2'd1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bin_show: got conv=%0b dm=%0d busy=%0b expected 0 1 0",
                  arith_bus.conversion_en, display_mode_out, busy);
      end
      checks++;
      if (arith_bus.op_latched !== 11'h001 || (start_count - start_before) !== 1) begin
         errors++;
         $display("[TB] FAIL bin_latch_pulses: got op=%0h pulses=%0d expected 001 1",
                  arith_bus.op_latched, start_count - start_before);
      end
      operation_in = 11'h001;
      press_next();
`ifdef CALC_CHAIN_EN
      checks++;
      if (operand_selection !== 2'd1 || chain_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL chain_enter_b: got sel=%0d chain=%0b expected 1 1", operand_selection, chain_out);
      end
      press_next();
      checks++;
      if (chain_out !== 1'b1 || operand_selection !== 2'd2) begin
         errors++;
         $display("[TB] FAIL chain_check: got chain=%0b sel=%0d expected 1 2", chain_out, operand_selection);
      end
      tick();
      checks++;
      if (chain_out !== 1'b0 || arith_bus.start_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL chain_launch: got chain=%0b start=%0b expected 0 1", chain_out, arith_bus.start_out);
      end
      press_clear();
`else
      checks++;
      if (operand_selection !== 2'd0 || display_mode_out !== 2'd0 || chain_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL show_exit: got sel=%0d dm=%0d chain=%0b expected 0 0 0",
                  operand_selection, display_mode_out, chain_out);
      end
`endif
   endtask

   task automatic test_unary();
      start_before = start_count;
      operation_in = 11'h400;
      press_next();
      checks++;
      if (operand_selection !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL unary_skip_b: got sel=%0d busy=%0b expected 2 1", operand_selection, busy);
      end
      tick();
      checks++;
      if (arith_bus.start_out !== 1'b1 || arith_bus.op_latched !== 11'h400) begin
         errors++;
         $display("[TB] FAIL unary_launch: got start=%0b op=%0h expected 1 400",
                  arith_bus.start_out, arith_bus.op_latched);
      end
      press_clear();
      checks++;
      if ((start_count - start_before) !== 1 || operand_selection !== 2'd0) begin
         errors++;
         $display("[TB] FAIL unary_pulses: got pulses=%0d sel=%0d expected 1 0",
                  start_count - start_before, operand_selection);
      end
   endtask

   task automatic test_invalid();
      logic [10:0] bad_ops [2];
      bad_ops[0] = 11'h003;
      bad_ops[1] = 11'h000;
      for (int i = 0; i < 2; i++) begin
         start_before = start_count;
         operation_in = bad_ops[i];
         press_next();
         press_next();
         tick();
         checks++;
         if (error_code !== 2'd1 || display_mode_out !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_err op=%0h: got err=%0d dm=%0d busy=%0b expected 1 2 0",
                     bad_ops[i], error_code, display_mode_out, busy);
         end
         tick();
         checks++;
         if (error_code !== 2'd1 || (start_count - start_before) !== 0) begin
            errors++;
            $display("[TB] FAIL invalid_hold op=%0h: got err=%0d pulses=%0d expected 1 0",
                     bad_ops[i], error_code, start_count - start_before);
         end
         if (i == 0) press_next();
         else        press_clear();
         checks++;
         if (error_code !== 2'd0 || display_mode_out !== 2'd0 || operand_selection !== 2'd0) begin
            errors++;
            $display("[TB] FAIL invalid_exit op=%0h: got err=%0d dm=%0d sel=%0d expected 0 0 0",
                     bad_ops[i], error_code, display_mode_out, operand_selection);
         end
      end
   endtask

   task automatic test_timeout();
      operation_in = 11'h001;
      press_next();
      press_next();
      tick();
      tick();
      repeat (15) tick();
      checks++;
      if (busy !== 1'b1 || error_code !== 2'd0) begin
         errors++;
         $display("[TB] FAIL timeout_early: got busy=%0b err=%0d expected 1 0", busy, error_code);
      end
      tick();
      checks++;
      if (error_code !== 2'd2 || display_mode_out !== 2'd2 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_wait: got err=%0d dm=%0d busy=%0b expected 2 2 0",
                  error_code, display_mode_out, busy);
      end
      press_next();
      checks++;
      if (error_code !== 2'd0) begin
         errors++;
         $display("[TB] FAIL timeout_ack: got err=%0d expected 0", error_code);
      end
      press_next();
      press_next();
      tick();
      tick();
      repeat (15) tick();
      arith_bus.result_ready_in = 1'b1;
      tick();
      arith_bus.result_ready_in = 1'b0;
      checks++;
      if (arith_bus.conversion_en !== 1'b1 || error_code !== 2'd0) begin
         errors++;
         $display("[TB] FAIL timeout_tie: got conv=%0b err=%0d expected 1 0", arith_bus.conversion_en, error_code);
      end
      repeat (15) tick();
      checks++;
      if (arith_bus.conversion_en !== 1'b1 || error_code !== 2'd0) begin
         errors++;
         $display("[TB] FAIL convert_early: got conv=%0b err=%0d expected 1 0", arith_bus.conversion_en, error_code);
      end
      tick();
      checks++;
      if (error_code !== 2'd2 || arith_bus.conversion_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL convert_timeout: got err=%0d conv=%0b expected 2 0", error_code, arith_bus.conversion_en);
      end
      press_clear();
   endtask

   task automatic test_abort();
      operation_in = 11'h002;
      press_next();
      press_next();
      tick();
      tick();
      tick();
      press_clear();
      operation_in = 11'h004;
      checks++;
      if (operand_selection !== 2'd0 || busy !== 1'b0 || arith_bus.op_latched !== 11'h002) begin
         errors++;
         $display("[TB] FAIL abort_wait: got sel=%0d busy=%0b op=%0h expected 0 0 002",
                  operand_selection, busy, arith_bus.op_latched);
      end
      arith_bus.result_ready_in = 1'b1;
      repeat (3) tick();
      arith_bus.result_ready_in = 1'b0;
      checks++;
      if (arith_bus.conversion_en !== 1'b0 || busy !== 1'b0 || operand_selection !== 2'd0) begin
         errors++;
         $display("[TB] FAIL abort_ignore: got conv=%0b busy=%0b sel=%0d expected 0 0 0",
                  arith_bus.conversion_en, busy, operand_selection);
      end
      operation_in = 11'h001;
      press_next();
      btn_next  = 1'b1;
      btn_clear = 1'b1;
      tick();
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      checks++;
      if (operand_selection !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_tie: got sel=%0d busy=%0b expected 0 0", operand_selection, busy);
      end
   endtask

   task automatic test_reset_convert();
      operation_in = 11'h001;
      press_next();
      press_next();
      tick();
      tick();
      arith_bus.result_ready_in = 1'b1;
      tick();
      arith_bus.result_ready_in = 1'b0;
      checks++;
      if (arith_bus.conversion_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_pre_convert: got conv=%0b expected 1", arith_bus.conversion_en);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({operand_selection, display_mode_out, busy, error_code, chain_out,
           arith_bus.start_out, arith_bus.conversion_en} !== 11'b0 ||
          arith_bus.op_latched !== 11'h000) begin
         errors++;
         $display("[TB] FAIL rst_async: got sel=%0d busy=%0b conv=%0b op=%0h expected all 0",
                  operand_selection, busy, arith_bus.conversion_en, arith_bus.op_latched);
      end
      reset = 1'b1;
      tick();
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      start_count  = 0;
      reset        = 1'b0;
      btn_next     = 1'b0;
      btn_clear    = 1'b0;
      operation_in = 11'h000;
      arith_bus.result_ready_in  = 1'b0;
      arith_bus.conversion_ready = 1'b0;
      #3;
      test_reset();
      test_binary();
      test_unary();
      test_invalid();
      test_timeout();
      test_abort();
      test_reset_convert();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
